// File: rtl/dbus_fabric.sv
// rtl/dbus_fabric.sv - data-bus fabric between the CPU data port and N memory-mapped targets
//
// Host side : i_req/i_addr/i_wdata/i_we/i_mode in; o_ready/o_rdata/o_err/o_busy/o_err_count out
// Target side: o_t_sel (one-hot)/o_t_addr/o_t_wdata/o_t_we/o_t_mode out; i_t_rdata (packed)/i_t_ack in
// clk rising edge; rst asynchronous active-low
module dbus_fabric #(
  parameter int          N_TGT    = 4,
  parameter int          SEL_W    = 2,
  parameter int          SEL_LSB  = 28,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic                 i_we,
  input  logic [2:0]           i_mode,
  output logic                 o_ready,
  output logic [31:0]          o_rdata,
  output logic                 o_err,
  output logic                 o_busy,
  output logic [15:0]          o_err_count,
  output logic [N_TGT-1:0]     o_t_sel,
  output logic [31:0]          o_t_addr,
  output logic [31:0]          o_t_wdata,
  output logic                 o_t_we,
  output logic [2:0]           o_t_mode,
  input  logic [32*N_TGT-1:0]  i_t_rdata,
  input  logic [N_TGT-1:0]     i_t_ack
);

  // Counter counts completed ACCESS cycles without ack: 0 .. TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [SEL_W-1:0] idx_reg;
  logic             we_reg;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] req_idx;
  logic             req_mapped;
  logic [N_TGT-1:0] req_onehot;
  logic             ack_sel;
  logic [31:0]      rdata_sel;

  assign req_idx    = i_addr[SEL_LSB +: SEL_W];
  assign req_mapped = (32'(req_idx) < 32'(N_TGT));

  // Decode of the incoming index, and mux of the latched target's ack/rdata.
  // Acks from any other target never reach the FSM.
  always_comb begin
    req_onehot = '0;
    ack_sel    = 1'b0;
    rdata_sel  = '0;
    for (int k = 0; k < N_TGT; k++) begin
      req_onehot[k] = (req_idx == SEL_W'(k));
      if (idx_reg == SEL_W'(k)) begin
        ack_sel   = i_t_ack[k];
        rdata_sel = i_t_rdata[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx_reg     <= '0;
      we_reg      <= 1'b0;
      cnt         <= '0;
      o_ready     <= 1'b0;
      o_rdata     <= '0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      o_err_count <= '0;
      o_t_sel     <= '0;
      o_t_addr    <= '0;
      o_t_wdata   <= '0;
      o_t_we      <= 1'b0;
      o_t_mode    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            o_t_addr  <= i_addr;
            o_t_wdata <= i_wdata;
            o_t_mode  <= i_mode;
            we_reg    <= i_we;
            idx_reg   <= req_idx;
            cnt       <= '0;
            o_busy    <= 1'b1;
            if (req_mapped) begin
              state   <= ACCESS;
              o_t_sel <= req_onehot;
              o_t_we  <= i_we;
            end else begin
              // Unmapped: skip ACCESS entirely, complete with error next cycle.
              state   <= RESP;
              o_ready <= 1'b1;
              o_err   <= 1'b1;
              o_rdata <= ERR_DATA;
              if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
            end
          end
        end
        ACCESS: begin
          // Ack is checked before the deadline so an ack in the last cycle wins.
          if (ack_sel) begin
            state   <= RESP;
            o_t_sel <= '0;
            o_t_we  <= 1'b0;
            o_ready <= 1'b1;
            o_err   <= 1'b0;
            o_rdata <= we_reg ? 32'd0 : rdata_sel;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= RESP;
            o_t_sel <= '0;
            o_t_we  <= 1'b0;
            o_ready <= 1'b1;
            o_err   <= 1'b1;
            o_rdata <= ERR_DATA;
            if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          o_ready <= 1'b0;
          o_err   <= 1'b0;
          o_rdata <= '0;
          o_busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
